// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared constants, FSM state type and width helper for the BCD converter
package bcd_pkg;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 3;
  localparam logic [DIGIT_W-1:0] ADD3_THRESH = 4'd5;
  localparam int MAX_DEC    = 999;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  // Bits needed to hold values 0..value-1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - double-dabble correction cell: add 3 to a BCD nibble that is 5 or more
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [DIGIT_W-1:0] adjusted
);

  assign adjusted = (digit >= ADD3_THRESH) ? digit + DIGIT_W'(3) : digit;

endmodule

// File: rtl/bcd_seq_converter.sv
// rtl/bcd_seq_converter.sv - signed binary to 3-digit BCD, one double-dabble bit per clock
// Optional CLAMP_999_EN: magnitudes above 999 display as 999 with ovf set.
module bcd_seq_converter
  import bcd_pkg::*;
#(
  parameter int DATA_W = 9
) (
  input  logic              clk_100MHz,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] din,
  output logic              busy,
  output logic              valid,
  output logic [3:0]        ones,
  output logic [3:0]        tens,
  output logic [3:0]        hundreds,
  output logic              sign,
  output logic              ovf
);

  localparam int CNT_W = clog2(DATA_W + 1);
  localparam int BCD_W = DIGIT_W * NUM_DIGITS;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  cnt;
  logic [BCD_W-1:0]  bcd;
  logic [BCD_W-1:0]  bcd_adj;
  logic [DATA_W-1:0] mag;
  logic [DATA_W-1:0] mag_in;
  logic              sign_q;
`ifdef CLAMP_999_EN
  logic              ovf_pend;
  logic              ovf_q;
`endif

  // Unsigned magnitude; the most negative input maps to 2^(DATA_W-1).
  assign mag_in = din[DATA_W-1] ? (~din + DATA_W'(1)) : din;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .digit    (bcd[g*DIGIT_W +: DIGIT_W]),
      .adjusted (bcd_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (cnt == CNT_W'(1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      bcd      <= '0;
      mag      <= '0;
      sign_q   <= 1'b0;
      valid    <= 1'b0;
      ones     <= '0;
      tens     <= '0;
      hundreds <= '0;
      sign     <= 1'b0;
`ifdef CLAMP_999_EN
      ovf_pend <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sign_q <= din[DATA_W-1];
            mag    <= mag_in;
            bcd    <= '0;
            cnt    <= CNT_W'(DATA_W);
`ifdef CLAMP_999_EN
            ovf_pend <= (int'(mag_in) > MAX_DEC);
`endif
          end
        end
        SHIFT: begin
          // Carry out of the hundreds nibble is dropped, so digits wrap mod 1000.
          bcd <= {bcd_adj[BCD_W-2:0], mag[DATA_W-1]};
          mag <= {mag[DATA_W-2:0], 1'b0};
          cnt <= cnt - CNT_W'(1);
        end
        DONE: begin
          valid <= 1'b1;
          sign  <= sign_q;
`ifdef CLAMP_999_EN
          ovf_q <= ovf_pend;
          if (ovf_pend) begin
            ones     <= 4'd9;
            tens     <= 4'd9;
            hundreds <= 4'd9;
          end else begin
            ones     <= bcd[3:0];
            tens     <= bcd[7:4];
            hundreds <= bcd[11:8];
          end
`else
          ones     <= bcd[3:0];
          tens     <= bcd[7:4];
          hundreds <= bcd[11:8];
`endif
        end
        default: ;
      endcase
    end
  end

`ifdef CLAMP_999_EN
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule
